// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single requests
// on the instruction bus and buffers returned words in a 2-entry queue.
module ifetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic [63:0] pc,
    output logic [31:0] raw_instr,
    output logic        valid
);

    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [63:0] ireq_addr_q, ireq_addr_d;
    logic [63:0] pc_q [2];
    logic [31:0] instr_q [2];

    logic resp;
    logic push;
    logic pop;
    logic pending;
    logic issue;

    assign valid      = (count_q != 2'd0);
    assign pc         = pc_q[rd_ptr_q];
    assign raw_instr  = instr_q[rd_ptr_q];
    assign ireq_valid = outstanding_q;
    assign ireq_addr  = ireq_addr_q;

    always_comb begin
        resp    = iresp_data_ok && outstanding_q;
        push    = resp && !discard_q && !redirect_valid;
        pop     = valid && !stall && !redirect_valid;
        pending = outstanding_q && !resp;

        count_d = count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (push) begin
            fetch_pc_d = ireq_addr_q + 64'd4;
        end

        // A live request that belongs to a flushed path must be drained
        discard_d = pending && (discard_q || redirect_valid);

        // Only issue when a queue slot is guaranteed for the response
        issue         = !pending && (count_d <= 2'd1);
        outstanding_d = pending || issue;
        ireq_addr_d   = issue ? fetch_pc_d : ireq_addr_q;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            ireq_addr_q   <= 64'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            ireq_addr_q   <= ireq_addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= 64'd0;
                instr_q[i] <= 32'd0;
            end
        end else if (push) begin
            pc_q[wr_ptr_q]    <= ireq_addr_q;
            instr_q[wr_ptr_q] <= iresp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: ideal and latent memory, stall,
// redirect (pending and coincident), address wrap and async reset.
module tb_ifetch_unit;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;

    int n_chk;
    int n_fail;
    int mem_lat;
    int age;

    ifetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .pc            (pc),
        .raw_instr     (raw_instr),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory answers in the mem_lat-th cycle of each request
    always_comb begin
        iresp_data_ok = ireq_valid && (age >= mem_lat - 1);
        iresp_data    = mem_word(ireq_addr);
    end

    always @(posedge clk) begin
        if (!ireq_valid || iresp_data_ok) age <= 0;
        else age <= age + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) check("count_le2", 64'(dut.count_q <= 2'd2), 64'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        step();
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_ireq_addr", ireq_addr, 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_instr", 64'(raw_instr), 64'd0);
        check("rst_count", 64'(dut.count_q), 64'd0);
        check("rst_outst", 64'(dut.outstanding_q), 64'd0);
        check("rst_discard", 64'(dut.discard_q), 64'd0);
        check("rst_fetch_pc", dut.fetch_pc_q, RST_PC);
        reset_n = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        mem_lat = 1;
        age     = 0;

        // Ideal memory streaming
        do_reset();
        step();
        check("first_req_v", 64'(ireq_valid), 64'd1);
        check("first_req_a", ireq_addr, RST_PC);
        check("first_valid", 64'(valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("str_valid", 64'(valid), 64'd1);
            check("str_pc", pc, RST_PC + 64'(4 * i));
            check("str_instr", 64'(raw_instr),
                  64'(mem_word(RST_PC + 64'(4 * i))));
            check("str_addr", ireq_addr, RST_PC + 64'(4 * (i + 1)));
        end

        // Backpressure from the first cycle
        do_reset();
        stall = 1'b1;
        step();
        step();
        check("bp_pc0", pc, RST_PC);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_count", 64'(dut.count_q), 64'd2);
            check("bp_req_drop", 64'(ireq_valid), 64'd0);
            check("bp_pc_hold", pc, RST_PC);
            check("bp_instr_hold", 64'(raw_instr), 64'(mem_word(RST_PC)));
        end
        stall = 1'b0;
        step();
        check("rel_pc1", pc, RST_PC + 64'd4);
        check("rel_req_v", 64'(ireq_valid), 64'd1);
        check("rel_req_a", ireq_addr, RST_PC + 64'd8);
        step();
        check("rel_pc2", pc, RST_PC + 64'd8);
        check("rel_instr2", 64'(raw_instr), 64'(mem_word(RST_PC + 64'd8)));
        step();
        check("rel_pc3", pc, RST_PC + 64'd12);

        // Redirect while a 3-cycle request is pending
        do_reset();
        mem_lat = 3;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        step();
        redirect_valid = 1'b0;
        check("rp_held_v", 64'(ireq_valid), 64'd1);
        check("rp_held_a", ireq_addr, RST_PC);
        check("rp_discard", 64'(dut.discard_q), 64'd1);
        check("rp_dok", 64'(iresp_data_ok), 64'd1);
        check("rp_valid0", 64'(valid), 64'd0);
        step();
        check("rp_new_a", ireq_addr, 64'h8000_1000);
        check("rp_dropped", 64'(valid), 64'd0);
        step();
        step();
        check("rp_wait", 64'(valid), 64'd0);
        step();
        check("rp_first_v", 64'(valid), 64'd1);
        check("rp_first_pc", pc, 64'h8000_1000);
        check("rp_first_in", 64'(raw_instr), 64'(mem_word(64'h8000_1000)));

        // Redirect coincident with data_ok and pop
        mem_lat = 1;
        step();
        check("co_pre_pc", pc, 64'h8000_1004);
        check("co_pre_dok", 64'(iresp_data_ok), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h9000_0000;
        step();
        redirect_valid = 1'b0;
        check("co_count", 64'(dut.count_q), 64'd0);
        check("co_valid", 64'(valid), 64'd0);
        check("co_req_a", ireq_addr, 64'h9000_0000);
        check("co_req_v", 64'(ireq_valid), 64'd1);
        step();
        check("co_pc", pc, 64'h9000_0000);
        check("co_instr", 64'(raw_instr), 64'(mem_word(64'h9000_0000)));

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wr_req_a", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wr_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_next_a", ireq_addr, 64'd0);

        // Async reset mid-request, no clock edge
        check("ar_pre_v", 64'(ireq_valid), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_ireq_v", 64'(ireq_valid), 64'd0);
        check("ar_ireq_a", ireq_addr, 64'd0);
        check("ar_valid", 64'(valid), 64'd0);
        check("ar_pc", pc, 64'd0);
        check("ar_instr", 64'(raw_instr), 64'd0);
        step();
        step();
        check("ar_hold_v", 64'(ireq_valid), 64'd0);
        reset_n = 1'b1;
        step();
        check("ar_restart_a", ireq_addr, RST_PC);
        check("ar_restart_v", 64'(ireq_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
